pc_predict: RTL and testbench
=============================

// Module: pc_predict
// PURPOSE
//  Parametrised fetch-stage program counter: the PC register, PC+INC, and a
//   direct-mapped branch target buffer (BTB) with 2-bit bimodal counters.
//  Sits ahead of instruction memory. Predicts the next PC each cycle.
//  Accepts a hold from hazard logic and a redirect/update from execute.
// PARAMETERS
//  XLEN          32            address width
//  RESET_VECTOR  32'h0000_0000 PC value after reset
//  INC           4             bytes per sequential step
//  BTB_ENTRIES   16            BTB depth; power of 2, >=2
// PORTS
//  clk            in   1     clock; all state updates on rising edge
//  rst            in   1     reset: asynchronous, active-low
//  stall          in   1     hold PC this cycle
//  redirect       in   1     execute detected mispredict; load redirect_pc
//  redirect_pc    in   XLEN  corrected next PC
//  upd_valid      in   1     resolved branch/jump info valid this cycle
//  upd_pc         in   XLEN  PC of resolved branch
//  upd_taken      in   1     branch outcome
//  upd_target     in   XLEN  resolved target
//  PC_out         out  XLEN  current PC (registered)
//  inc_PC         out  XLEN  PC_out + INC (comb; feeds result mux)
//  pred_taken     out  1     BTB hit && counter[1] for PC_out (comb)
//  pred_target    out  XLEN  BTB target for PC_out (undefined if !pred_taken)
// BEHAVIOUR
//  Reset (rst=0, async):
//   - PC_out=RESET_VECTOR.
//   - All BTB valid bits = 0, so pred_taken=0.
//   - Target/tag/counter arrays are not reset.
//  Indexing (IW=$clog2(BTB_ENTRIES)):
//   - idx = pc[IW+1:2]
//   - tag = pc[XLEN-1:IW+2]
//   - hit = valid[idx] && tag match
//  Next-PC priority, highest first:
//   - redirect -> redirect_pc. Overrides stall.
//   - stall -> hold PC_out.
//   - pred_taken -> pred_target.
//   - otherwise -> inc_PC.
//  Latency:
//   - Prediction is the same cycle as PC_out. Predicted target appears on PC_out next edge.
//   - A redirect appears on PC_out 1 cycle after assertion.
//  Arithmetic: inc_PC wraps modulo 2^XLEN (all-ones-3 + 4 -> 0). No carry out.
//  BTB update (upd_valid=1, independent of stall/redirect):
//   - Tag hit: counter +1 if taken / -1 if not, saturating at 0 and 3.
//     If taken, the target is overwritten with upd_target.
//   - Tag miss, taken: allocate/replace entry. valid=1, tag, target, counter=2'b10.
//   - Tag miss, not taken: no change.
//  Counter states: 00 SNT, 01 WNT, 10 WT, 11 ST. Predict taken iff counter[1]=1.
//  Same-cycle lookup and update, same index: lookup uses pre-edge contents.
//   Write-first is NOT allowed.
//  Reset mid-operation: PC and valid bits clear immediately. In-flight update is dropped.
// STRUCTURE
//  Package pc_pkg:
//   - typedef logic [1:0] bim_ctr_t
//   - constants CTR_SNT/WNT/WT/ST and CTR_ALLOC=CTR_WT
//   - function sat_update(bim_ctr_t, logic taken)
//  Sub-module btb:
//   - Owns the valid/tag/target/counter arrays.
//   - One combinational read port (PC_out) and one synchronous write port (update).
//  pc_predict holds the PC register, the incrementer and the next-PC mux.
// TESTING
//  1 rst low mid-run -> PC_out=RESET_VECTOR at once; first edge after release -> 0x4.
//  2 stall=1 for 3 cycles at PC=0x8 -> PC_out stays 0x8.
//    stall=1 with redirect=1, redirect_pc=0x100 -> PC_out=0x100 next cycle.
//  3 upd pc=0x10 taken target=0x40 -> entry alloc, ctr=WT.
//    Then PC reaches 0x10 -> pred_taken=1, next PC_out=0x40.
//  4 Two not-taken updates at 0x10 -> ctr WT->WNT->SNT.
//    pred_taken=0 at 0x10; next PC_out=0x14. A further not-taken stays SNT.
//  5 Alias: upd 0x10 then 0x50 taken (BTB_ENTRIES=16, same idx) -> 0x50 replaces.
//    Lookup at 0x10 -> no hit.
//  6 Update at idx of current PC same cycle -> prediction uses old entry.
//    PC=0xFFFF_FFFC, no hit -> PC_out wraps to 0x0.

Source files
------------

// File: rtl/pc_predict_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pc_pkg
// Brief   : Shared types and helpers for the fetch-stage PC predictor.
// Rev     : 1.0  initial release
// ============================================================================
package pc_pkg;

  typedef logic [1:0] bim_ctr_t;

  localparam bim_ctr_t CTR_SNT   = 2'b00;
  localparam bim_ctr_t CTR_WNT   = 2'b01;
  localparam bim_ctr_t CTR_WT    = 2'b10;
  localparam bim_ctr_t CTR_ST    = 2'b11;
  localparam bim_ctr_t CTR_ALLOC = CTR_WT;

  function automatic bim_ctr_t sat_update(input bim_ctr_t ctr, input logic taken);
    bim_ctr_t r;
    r = ctr;
    if (taken) begin
      if (ctr != CTR_ST) r = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) r = ctr - 2'd1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_predict_if.sv
`default_nettype none
// ============================================================================
// Module  : pc_predict_if
// Brief   : Hazard/execute-side control and prediction outputs of pc_predict.
// Rev     : 1.0  initial release
// ============================================================================
interface pc_predict_if #(
  parameter int XLEN = 32
);

  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic [XLEN-1:0] PC_out;
  logic [XLEN-1:0] inc_PC;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  modport master (
    output stall, redirect, redirect_pc,
    output upd_valid, upd_pc, upd_taken, upd_target,
    input  PC_out, inc_PC, pred_taken, pred_target
  );

  modport slave (
    input  stall, redirect, redirect_pc,
    input  upd_valid, upd_pc, upd_taken, upd_target,
    output PC_out, inc_PC, pred_taken, pred_target
  );

endinterface
`default_nettype wire

// File: rtl/pc_predict_btb.sv
`default_nettype none
// ============================================================================
// Module  : btb
// Brief   : Direct-mapped branch target buffer with 2-bit bimodal counters;
//           one combinational read port, one synchronous update port.
// Rev     : 1.0  initial release
// ============================================================================
module btb
  import pc_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic [XLEN-1:0] i_rd_pc,
  output logic                 o_rd_hit,
  output bim_ctr_t             o_rd_ctr,
  output logic      [XLEN-1:0] o_rd_target,
  input  wire logic            i_wr_en,
  input  wire logic [XLEN-1:0] i_wr_pc,
  input  wire logic            i_wr_taken,
  input  wire logic [XLEN-1:0] i_wr_target
);

  localparam int IW = $clog2(BTB_ENTRIES);
  localparam int TW = XLEN - IW - 2;

  logic [BTB_ENTRIES-1:0] r_valid;
  logic [TW-1:0]          r_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]        r_target [BTB_ENTRIES];
  bim_ctr_t               r_ctr    [BTB_ENTRIES];

  logic [IW-1:0] w_rd_idx;
  logic [TW-1:0] w_rd_tag;
  logic [IW-1:0] w_wr_idx;
  logic [TW-1:0] w_wr_tag;
  logic          w_wr_hit;
  logic          w_alloc;
  logic          w_unused;

  assign w_rd_idx = i_rd_pc[IW+1:2];
  assign w_rd_tag = i_rd_pc[XLEN-1:IW+2];
  assign w_wr_idx = i_wr_pc[IW+1:2];
  assign w_wr_tag = i_wr_pc[XLEN-1:IW+2];
  assign w_unused = ^{i_rd_pc[1:0], i_wr_pc[1:0]};

  // Read port sees pre-edge contents, so a same-cycle update never bypasses.
  assign o_rd_hit    = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
  assign o_rd_ctr    = r_ctr[w_rd_idx];
  assign o_rd_target = r_target[w_rd_idx];

  assign w_wr_hit = r_valid[w_wr_idx] && (r_tag[w_wr_idx] == w_wr_tag);
  assign w_alloc  = i_wr_en && !w_wr_hit && i_wr_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (w_alloc) begin
      r_valid[w_wr_idx] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; an update coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && i_wr_en) begin
      if (w_wr_hit) begin
        r_ctr[w_wr_idx] <= sat_update(r_ctr[w_wr_idx], i_wr_taken);
        if (i_wr_taken) begin
          r_target[w_wr_idx] <= i_wr_target;
        end
      end else if (i_wr_taken) begin
        r_tag[w_wr_idx]    <= w_wr_tag;
        r_target[w_wr_idx] <= i_wr_target;
        r_ctr[w_wr_idx]    <= CTR_ALLOC;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_predict.sv
`default_nettype none
// ============================================================================
// Module  : pc_predict
// Brief   : Fetch-stage PC register, sequential incrementer and BTB-driven
//           next-PC selection with hold and redirect.
// Rev     : 1.0  initial release
// ============================================================================
module pc_predict
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INC          = 4,
  parameter int              BTB_ENTRIES  = 16
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  pc_predict_if.slave bus
);

  localparam logic [XLEN-1:0] c_INC = XLEN'(INC);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_inc_pc;
  logic [XLEN-1:0] w_next_pc;
  logic            w_rd_hit;
  bim_ctr_t        w_rd_ctr;
  logic [XLEN-1:0] w_rd_target;
  logic            w_pred_taken;
  logic            w_unused;

  btb #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rd_pc     (r_pc),
    .o_rd_hit    (w_rd_hit),
    .o_rd_ctr    (w_rd_ctr),
    .o_rd_target (w_rd_target),
    .i_wr_en     (bus.upd_valid),
    .i_wr_pc     (bus.upd_pc),
    .i_wr_taken  (bus.upd_taken),
    .i_wr_target (bus.upd_target)
  );

  // Wraps modulo 2^XLEN; carry out is discarded.
  assign w_inc_pc     = r_pc + c_INC;
  assign w_pred_taken = w_rd_hit && w_rd_ctr[1];
  assign w_unused     = w_rd_ctr[0];

  always_comb begin
    w_next_pc = w_inc_pc;
    if (bus.redirect) begin
      w_next_pc = bus.redirect_pc;
    end else if (bus.stall) begin
      w_next_pc = r_pc;
    end else if (w_pred_taken) begin
      w_next_pc = w_rd_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_VECTOR;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  assign bus.PC_out      = r_pc;
  assign bus.inc_PC      = w_inc_pc;
  assign bus.pred_taken  = w_pred_taken;
  assign bus.pred_target = w_rd_target;

endmodule
`default_nettype wire

// File: tb/tb_pc_predict.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_predict
// Brief   : Scoreboard bench for pc_predict against an array-based BTB model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_pc_predict;

  localparam int          XLEN = 32;
  localparam int          N    = 16;
  localparam int          IW   = $clog2(N);
  localparam logic [31:0] RV   = 32'h0000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_predict_if #(.XLEN(XLEN)) bus ();

  pc_predict #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RV),
    .INC          (4),
    .BTB_ENTRIES  (N)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inc;
    logic        pt;
    logic [31:0] tgt;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference state: PC plus one record per BTB slot.
  logic [31:0] m_pc;
  logic        m_valid [N];
  logic [31:0] m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IW + 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("PC_out", bus.PC_out, e.pc);
      chk("inc_PC", bus.inc_PC, e.inc);
      chk("pred_taken", {31'b0, bus.pred_taken}, {31'b0, e.pt});
      if (e.pt) chk("pred_target", bus.pred_target, e.tgt);
    end
  end

  task automatic model_update(input logic [31:0] upc, input logic ut, input logic [31:0] utgt);
    int i;
    i = idx_of(upc);
    if (m_valid[i] && m_tag[i] == tag_of(upc)) begin
      m_ctr[i] = ut ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                    : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
      if (ut) m_tgt[i] = utgt;
    end else if (ut) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = tag_of(upc);
      m_tgt[i]   = utgt;
      m_ctr[i]   = 2;
    end
  endtask

  // Entered and left just after a rising edge.
  task automatic step(input logic s, input logic r, input logic [31:0] rpc,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utgt);
    exp_t e;
    int   i;
    bus.stall       = s;
    bus.redirect    = r;
    bus.redirect_pc = rpc;
    bus.upd_valid   = uv;
    bus.upd_pc      = upc;
    bus.upd_taken   = ut;
    bus.upd_target  = utgt;
    i     = idx_of(m_pc);
    e.pc  = m_pc;
    e.inc = m_pc + 32'd4;
    e.pt  = m_valid[i] && (m_tag[i] == tag_of(m_pc)) && (m_ctr[i] >= 2);
    e.tgt = m_tgt[i];
    q.push_back(e);
    @(posedge clk);
    if (r)        m_pc = rpc;
    else if (!s)  m_pc = e.pt ? e.tgt : e.inc;
    if (uv) model_update(upc, ut, utgt);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic redir(input logic [31:0] pc);
    step(1'b0, 1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    step(1'b0, 1'b0, 32'h0, 1'b1, pc, t, tgt);
  endtask

  // Holds reset for one edge while an update is offered; that update must be lost.
  task automatic do_reset(input logic uv, input logic [31:0] upc, input logic [31:0] utgt);
    exp_t e;
    rst_n           = 1'b0;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.upd_valid   = uv;
    bus.upd_pc      = upc;
    bus.upd_taken   = 1'b1;
    bus.upd_target  = utgt;
    m_pc = RV;
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    e.pc  = RV;
    e.inc = RV + 32'd4;
    e.pt  = 1'b0;
    e.tgt = 32'h0;
    q.push_back(e);
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.upd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        s, r, uv, ut;
    logic [31:0] rpc, upc, utgt;

    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0; bus.upd_target = '0;
    @(posedge clk);
    #1;
    do_reset(1'b0, 32'h0, 32'h0);

    // Walk to 0x8, hold, then redirect under stall.
    idle(2);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(1);

    // Allocation and taken prediction.
    upd(32'h10, 1'b1, 32'h40);
    redir(32'h10);
    idle(2);

    // Train down to SNT and saturate there.
    upd(32'h10, 1'b0, 32'h0);
    upd(32'h10, 1'b0, 32'h0);
    redir(32'h10);
    idle(2);
    upd(32'h10, 1'b0, 32'h0);
    redir(32'h10);
    idle(1);

    // Alias replacement at index 4.
    upd(32'h10, 1'b1, 32'h40);
    upd(32'h50, 1'b1, 32'h80);
    redir(32'h10);
    idle(1);

    // Same-cycle lookup and update: lookup sees the old target.
    redir(32'h50);
    upd(32'h50, 1'b1, 32'h200);
    idle(1);
    redir(32'h50);
    idle(2);

    // Wraparound.
    redir(32'hFFFF_FFFC);
    idle(2);

    // Mid-run reset with an update in flight.
    idle(1);
    do_reset(1'b1, 32'h10, 32'h300);
    idle(6);

    for (int k = 0; k < 400; k++) begin
      if (k == 200) do_reset(1'b1, 32'h0, 32'h20);
      s    = ($urandom % 8) == 0;
      r    = ($urandom % 10) == 0;
      rpc  = (($urandom % 6) == 0) ? 32'hFFFF_FFFC : (32'($urandom_range(0, 63)) << 2);
      uv   = ($urandom % 2) == 1;
      upc  = 32'($urandom_range(0, 127)) << 2;
      ut   = ($urandom % 3) != 0;
      utgt = 32'($urandom_range(0, 127)) << 2;
      step(s, r, rpc, uv, upc, ut, utgt);
    end

    @(negedge clk);
    #1;
    chk("queue_drain", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
